// File: rtl/mem_access_unit_pkg.sv
// Shared codes for the memory access unit: op/size encodings, FSM states, request legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_access_pkg;

   typedef enum logic [1:0] {
      OP_FETCH = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LD_ISSUE,
      LD_CAP,
      RMW_ISSUE,
      RMW_CAP,
      ST_WR,
      RESP
   } state_e;

   // A request is rejected for a reserved code or an address not aligned to its access size.
   // Fetches are always whole words, so their size field plays no part.
   function automatic logic req_bad(op_e op, size_e sz, logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (op)
         OP_FETCH: bad = (off != 2'b00);
         OP_RSVD:  bad = 1'b1;
         default: begin
            case (sz)
               SZ_BYTE: bad = 1'b0;
               SZ_HALF: bad = off[0];
               SZ_WORD: bad = (off != 2'b00);
               default: bad = 1'b1;
            endcase
         end
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle between controller, access unit and memory.
// Latency: n/a (wires only).
// Backpressure: req_ready from the unit gates acceptance; no other flow control.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic              rsp_err;

   logic [31:0]       mem_A;
   logic [31:0]       mem_WD;
   logic              mem_WE;
   logic              mem_adrSrc;
   logic [31:0]       mem_readData;

   // Controller plus memory side.
   modport master (
      output req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
      input  req_ready, rsp_valid, rsp_data, rsp_err, mem_A, mem_WD, mem_WE, mem_adrSrc
   );

   // Access unit side.
   modport slave (
      input  req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
      output req_ready, rsp_valid, rsp_data, rsp_err, mem_A, mem_WD, mem_WE, mem_adrSrc
   );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte/half lane handling: extracts and extends load data, merges store data into an old word.
// Latency: combinational.
// Backpressure: none.
module mau_lane_align
   import mem_access_pkg::*;
(
   input  size_e       size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Little-endian lane pick, then sign- or zero-extend; a word passes through untouched.
   always_comb begin
      byte_sel = rdata_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (size_i)
         SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: load_o = rdata_i;
      endcase
   end

   // Replace only the addressed lane of the old word with the low bits of the store data.
   always_comb begin
      merge_o = rdata_i;
      case (size_i)
         SZ_BYTE: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         SZ_HALF: begin
            if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
            else          merge_o[15:0]  = wdata_i[15:0];
         end
         default: merge_o = wdata_i;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding fetch/load/store sequencer in front of a split instruction/data memory.
// Latency: rsp_valid 1 cycle after accept (error), 2 (fetch, word store), 3 (load), 4 (sub-word store).
// Backpressure: req_ready only in IDLE; requests seen while busy are dropped, not queued.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);
   state_e      state_q;
   size_e       size_q;
   logic        uns_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rsp_data_q;
   logic [31:0] mem_a_q;
   logic [31:0] mem_wd_q;
   logic        mem_we_q;
   logic        mem_src_q;

   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       addr32;
   logic [31:0]       word_idx;
   op_e               req_op;
   size_e             req_size;
   logic              bad;
   logic [31:0]       load_val;
   logic [31:0]       merge_val;

   assign req_addr = bus.req_addr;
   assign addr32   = 32'(req_addr);
   assign word_idx = {2'b00, addr32[31:2]};
   assign req_op   = op_e'(bus.req_op);
   assign req_size = size_e'(bus.req_size);
   assign bad      = req_bad(req_op, req_size, addr32[1:0]);

   mau_lane_align u_align (
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .off_i      (off_q),
      .rdata_i    (bus.mem_readData),
      .wdata_i    (wdata_q),
      .load_o     (load_val),
      .merge_o    (merge_val)
   );

   // Sequencer: every output is registered alongside the state it belongs to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         mem_a_q     <= '0;
         mem_wd_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_src_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  size_q  <= req_size;
                  uns_q   <= bus.req_unsigned;
                  off_q   <= addr32[1:0];
                  wdata_q <= bus.req_wdata;
                  if (bad) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                  end else begin
                     case (req_op)
                        OP_FETCH: begin
                           state_q   <= FETCH;
                           mem_a_q   <= addr32;
                           mem_src_q <= 1'b0;
                        end
                        OP_LOAD: begin
                           state_q   <= LD_ISSUE;
                           mem_a_q   <= word_idx;
                           mem_src_q <= 1'b1;
                        end
                        default: begin
                           mem_a_q   <= word_idx;
                           mem_src_q <= 1'b1;
                           if (req_size == SZ_WORD) begin
                              state_q  <= ST_WR;
                              mem_we_q <= 1'b1;
                              mem_wd_q <= bus.req_wdata;
                           end else begin
                              state_q  <= RMW_ISSUE;
                           end
                        end
                     endcase
                  end
               end
            end
            FETCH: begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= bus.mem_readData;
               mem_a_q     <= '0;
            end
            LD_ISSUE:  state_q <= LD_CAP;
            LD_CAP: begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= load_val;
               mem_a_q     <= '0;
               mem_src_q   <= 1'b0;
            end
            RMW_ISSUE: state_q <= RMW_CAP;
            RMW_CAP: begin
               // Old word is on mem_readData now; write back with only the target lane changed.
               state_q  <= ST_WR;
               mem_we_q <= 1'b1;
               mem_wd_q <= merge_val;
            end
            ST_WR: begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= '0;
               mem_we_q    <= 1'b0;
               mem_wd_q    <= '0;
               mem_a_q     <= '0;
               mem_src_q   <= 1'b0;
            end
            RESP: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_data_q  <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.mem_A      = mem_a_q;
   assign bus.mem_WD     = mem_wd_q;
   assign bus.mem_WE     = mem_we_q;
   assign bus.mem_adrSrc = mem_src_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed pins plus randomized requests against a request-level model.
// Latency: model predicts a per-cycle expectation list for each transaction.
// Backpressure: requests only issued in idle cycles; busy cycles carry random ignored requests.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(32)) bus ();
   mem_access_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Environment memory: instruction array read combinationally, data array read registered.
   logic [31:0] imem    [0:255];
   logic [31:0] dmem    [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] dmem_rd;

   assign bus.mem_readData = bus.mem_adrSrc ? dmem_rd : imem[bus.mem_A[9:2]];

   // Data array port.
   always @(posedge clk) begin
      dmem_rd <= dmem[bus.mem_A[7:0]];
      if (bus.mem_WE) dmem[bus.mem_A[7:0]] <= bus.mem_WD;
   end

   int total = 0;
   int bad   = 0;
   logic [31:0] last_rsp_data;
   logic        last_rsp_err;

   typedef struct {
      bit          rdy;
      bit          rv;
      bit          err;
      logic [31:0] data;
      bit          we;
      bit          chk_src;
      bit          src;
      bit          chk_a;
      logic [31:0] a;
      bit          chk_wd;
      logic [31:0] wd;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
      end
   endtask

   function automatic exp_t busy_rec();
      exp_t r;
      r = '{default: 0};
      return r;
   endfunction

   function automatic exp_t idle_rec();
      exp_t r;
      r = '{default: 0};
      r.rdy = 1; r.chk_src = 1; r.chk_a = 1; r.chk_wd = 1;
      return r;
   endfunction

   // Compare the DUT against the expectation for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("req_ready", 32'(bus.req_ready), 32'(e.rdy));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.rv));
         chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
         chk("rsp_data",  bus.rsp_data,       e.data);
         chk("mem_WE",    32'(bus.mem_WE),    32'(e.we));
         if (e.chk_src) chk("mem_adrSrc", 32'(bus.mem_adrSrc), 32'(e.src));
         if (e.chk_a)   chk("mem_A",  bus.mem_A,  e.a);
         if (e.chk_wd)  chk("mem_WD", bus.mem_WD, e.wd);
         if (bus.rsp_valid) begin
            last_rsp_data = bus.rsp_data;
            last_rsp_err  = bus.rsp_err;
         end
      end
   end

   task automatic scribble(input bit allow_valid);
      bus.req_valid    = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.req_op       = 2'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
   endtask

   // Issue one request from an idle cycle (entered at posedge+2) and schedule its expected cycles.
   task automatic do_txn(input logic [1:0] op, input logic [1:0] sz, input logic un,
                         input logic [31:0] addr, input logic [31:0] wdata, input int gap);
      exp_t        s[$];
      exp_t        r;
      logic [31:0] w, dat, mask, nv, lane;
      int          sh;
      bit          is_bad;
      repeat (gap) begin
         scribble(0);
         exp_q.push_back(idle_rec());
         @(posedge clk); #2;
      end
      sh = 8 * int'(addr[1:0]);
      is_bad = (op == 2'd3) ||
               (op == 2'd0 && addr[1:0] != 2'b00) ||
               (op != 2'd0 && sz == 2'd3) ||
               (op != 2'd0 && sz == 2'd1 && addr[0]) ||
               (op != 2'd0 && sz == 2'd2 && addr[1:0] != 2'b00);
      s.push_back(idle_rec());
      if (is_bad) begin
         r = busy_rec(); r.rv = 1; r.err = 1; r.chk_src = 1; r.src = 0;
         s.push_back(r);
      end else if (op == 2'd0) begin
         r = busy_rec(); r.chk_src = 1; r.src = 0; r.chk_a = 1; r.a = addr;
         s.push_back(r);
         r = busy_rec(); r.rv = 1; r.data = imem[addr[9:2]];
         s.push_back(r);
      end else if (op == 2'd1) begin
         w = ref_mem[addr[9:2]];
         if (sz == 2'd0) begin
            lane = (w >> sh) & 32'h0000_00FF;
            dat  = (!un && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
         end else if (sz == 2'd1) begin
            lane = (w >> sh) & 32'h0000_FFFF;
            dat  = (!un && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
         end else begin
            dat = w;
         end
         repeat (2) begin
            r = busy_rec(); r.chk_src = 1; r.src = 1; r.chk_a = 1; r.a = addr >> 2;
            s.push_back(r);
         end
         r = busy_rec(); r.rv = 1; r.data = dat;
         s.push_back(r);
      end else begin
         if (sz == 2'd2) begin
            nv = wdata;
         end else begin
            w    = ref_mem[addr[9:2]];
            mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
            nv   = (w & ~mask) | ((wdata << sh) & mask);
            repeat (2) begin
               r = busy_rec(); r.chk_src = 1; r.src = 1; r.chk_a = 1; r.a = addr >> 2;
               s.push_back(r);
            end
         end
         r = busy_rec(); r.we = 1; r.chk_src = 1; r.src = 1; r.chk_a = 1; r.a = addr >> 2;
         r.chk_wd = 1; r.wd = nv;
         s.push_back(r);
         r = busy_rec(); r.rv = 1;
         s.push_back(r);
         ref_mem[addr[9:2]] = nv;
      end
      exp_q.push_back(s[0]);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_size = sz; bus.req_unsigned = un;
      bus.req_addr = addr; bus.req_wdata = wdata;
      @(posedge clk); #2;
      for (int k = 1; k < s.size(); k++) begin
         exp_q.push_back(s[k]);
         scribble(1);
         @(posedge clk); #2;
      end
      scribble(0);
   endtask

   initial begin
      logic [1:0]  op, sz;
      logic [31:0] addr;
      int          pick;
      for (int i = 0; i < 256; i++) begin
         imem[i]    = $urandom;
         dmem[i]    = $urandom;
         ref_mem[i] = dmem[i];
      end
      imem[2] = 32'h0050_0093;
      last_rsp_data = '0;
      last_rsp_err  = 1'b0;
      scribble(0);
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      chk("rst_rsp_data",  bus.rsp_data,       32'd0);
      chk("rst_mem_WE",    32'(bus.mem_WE),    32'd0);
      chk("rst_adrSrc",    32'(bus.mem_adrSrc), 32'd0);
      chk("rst_mem_A",     bus.mem_A,          32'd0);
      chk("rst_mem_WD",    bus.mem_WD,         32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #2;

      // Directed pins.
      do_txn(2'd0, 2'd0, 1'b0, 32'h0000_0008, 32'h0, 0);
      chk("pin_fetch_data", last_rsp_data, 32'h0050_0093);
      chk("pin_fetch_err",  32'(last_rsp_err), 32'd0);
      do_txn(2'd2, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0);
      chk("pin_word_store_mem", dmem[64], 32'hDEAD_BEEF);
      do_txn(2'd1, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0);
      chk("pin_lb_signed", last_rsp_data, 32'hFFFF_FFDE);
      do_txn(2'd1, 2'd1, 1'b1, 32'h0000_0100, 32'h0, 1);
      chk("pin_lhu", last_rsp_data, 32'h0000_BEEF);
      do_txn(2'd2, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_0012, 0);
      do_txn(2'd1, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0);
      chk("pin_rmw_readback", last_rsp_data, 32'hDEAD_12EF);
      do_txn(2'd1, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 0);
      chk("pin_misaligned_err",  32'(last_rsp_err), 32'd1);
      chk("pin_misaligned_data", last_rsp_data, 32'd0);

      // Reset while a half store sits in its write cycle.
      bus.req_valid = 1'b1; bus.req_op = 2'd2; bus.req_size = 2'd1; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h0000_0102; bus.req_wdata = 32'h0000_5555;
      @(posedge clk); #2;
      scribble(0);
      repeat (2) begin @(posedge clk); #2; end
      chk("rst_mid_pre_we", 32'(bus.mem_WE), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_mid_we_drop", 32'(bus.mem_WE), 32'd0);
      chk("rst_mid_adrSrc",  32'(bus.mem_adrSrc), 32'd0);
      chk("rst_mid_mem_A",   bus.mem_A, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready_after", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #2;
      chk("rst_mid_word_unchanged", dmem[64], 32'hDEAD_12EF);
      do_txn(2'd1, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0);
      chk("pin_after_reset_load", last_rsp_data, 32'hDEAD_12EF);

      // Randomized traffic.
      for (int t = 0; t < 300; t++) begin
         pick = $urandom_range(0, 15);
         op = (pick < 3) ? 2'd0 : (pick < 9) ? 2'd1 : (pick < 15) ? 2'd2 : 2'd3;
         pick = $urandom_range(0, 9);
         sz = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
         addr = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 9) < 8) begin
            if (op == 2'd0 || sz == 2'd2) addr = addr & ~32'd3;
            else if (sz == 2'd1)          addr = addr & ~32'd1;
         end
         do_txn(op, sz, 1'($urandom), addr, $urandom, $urandom_range(0, 2));
      end

      @(posedge clk); #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32: processor byte-address width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  controller request strobe.
REQ-005 req_ready  output  1  unit accepts a request; high only in IDLE.
REQ-006 req_op  input  2  00 fetch, 01 load, 10 store, 11 reserved.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved; ignored for fetch.
REQ-008 req_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_data  output  32  fetched word or extended load value; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned address or reserved code; qualified by rsp_valid.
REQ-014 mem_A  output  32  memory address.
REQ-015 mem_WD  output  32  memory write data.
REQ-016 mem_WE  output  1  memory write enable.
REQ-017 mem_adrSrc  output  1  0 selects instruction array, 1 selects data array.
REQ-018 mem_readData  input  32  memory read data: combinational when adrSrc=0; registered at the clock edge when adrSrc=1.

Function
REQ-019 Accept occurs on a rising edge with req_valid=1 in IDLE; op, size, unsigned, addr and wdata SHALL be latched then, and later input changes SHALL be ignored.
REQ-020 FSM states: IDLE, FETCH, LD_ISSUE, LD_CAP, RMW_ISSUE, RMW_CAP, ST_WR, RESP; RESP SHALL always return to IDLE.
REQ-021 Fetch: IDLE->FETCH->RESP; mem_adrSrc=0; mem_A=latched byte address; mem_readData captured at the end of FETCH; rsp_valid in the 2nd cycle after accept.
REQ-022 Load: IDLE->LD_ISSUE->LD_CAP->RESP; mem_adrSrc=1; mem_WE=0; capture at the end of LD_CAP; rsp_valid in the 3rd cycle after accept.
REQ-023 Data-array mem_A SHALL be the word index {2'b00, addr[31:2]} in LD_ISSUE, LD_CAP, RMW_ISSUE, RMW_CAP and ST_WR.
REQ-024 Load lane select: little-endian by addr[1:0] for bytes and addr[1] for halves; sign- or zero-extend per req_unsigned; a word load SHALL return the word unchanged.
REQ-025 Word store: IDLE->ST_WR->RESP; mem_WE=1 for exactly one cycle with mem_WD=wdata.
REQ-026 Sub-word store: IDLE->RMW_ISSUE->RMW_CAP->ST_WR->RESP (read-modify-write); old word captured at the end of RMW_CAP; only the addressed byte or half is replaced from wdata[7:0] or wdata[15:0].
REQ-027 mem_WE SHALL be 1 only in ST_WR, and mem_adrSrc SHALL be 1 in all data states.
REQ-028 Misalignment (half with addr[0]=1; word or fetch with addr[1:0]!=0) or a reserved op/size SHALL go IDLE->RESP with no memory access: rsp_err=1, rsp_data=0.
REQ-029 rsp_valid=1 only in RESP; rsp_data and rsp_err SHALL hold their values through RESP and be 0 otherwise.
REQ-030 In IDLE, mem_A, mem_WD, mem_WE and mem_adrSrc SHALL all be 0.
REQ-031 req_valid asserted in a non-IDLE state SHALL be ignored; there is no request queue.

Reset
REQ-032 Assertion of rst SHALL immediately force IDLE and clear all registers: rsp_valid=0, rsp_err=0, rsp_data=0, mem_WE=0, mem_adrSrc=0, mem_A=0, mem_WD=0.
REQ-033 Reset during ST_WR SHALL deassert mem_WE combinationally, and an interrupted RMW SHALL NOT be completed after reset release.
REQ-034 req_ready SHALL be high in the first cycle after rst deasserts.

Structure
REQ-035 Package mem_access_pkg SHALL hold the op codes, size codes and the state enumeration.
REQ-036 Sub-module mau_lane_align SHALL be purely combinational and perform load extraction/extension and store byte/half merge.

Verification
REQ-037 Fetch addr 0x00000008, instr word 2 = 0x00500093 -> mem_A=0x8, adrSrc=0; rsp_data=0x00500093, rsp_err=0, 2 cycles after accept.
REQ-038 Word store 0xDEADBEEF at 0x100, then signed byte load at 0x103 -> WE one cycle with mem_A=0x40; load returns 0xFFFFFFDE; unsigned half load at 0x100 returns 0x0000BEEF.
REQ-039 Byte store 0x12 at 0x101 over word 0xDEADBEEF -> RMW sequence with WE in cycle 3 only; word reads back 0xDEAD12EF.
REQ-040 Word load at 0x102 -> rsp_err=1, rsp_data=0 in the cycle after accept; mem_WE and mem_adrSrc stay 0 throughout.
REQ-041 rst asserted mid ST_WR of a sub-word store -> mem_WE drops the same cycle and the word is unchanged; req_ready=1 in the first cycle after release.
